// File: rtl/axi_pkg.sv
// Shared types for the AXI write-data sink: response codes, sink FSM
// states and the saturating error-counter helper.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    RESP   = 1'b1
  } sink_state_t;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == ERR_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_w_sink_chk.sv
// Protocol and occupancy properties for the write sink, bound in by the top.
module axi_w_sink_chk
  import axi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  input sink_state_t            state,
  input logic                   wvalid,
  input logic                   wready,
  input logic                   bvalid,
  input logic                   bready,
  input logic [1:0]             bresp,
  input logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);

  a_bresp_stable: assert property (
    @(posedge clk) disable iff (rst)
    (bvalid && !bready) |=> (bvalid && $stable(bresp))
  );

  a_count_max: assert property (
    @(posedge clk) disable iff (rst)
    fifo_count <= MAX_CNT
  );

  // An underflow from zero would wrap to a value far above one.
  a_count_underflow: assert property (
    @(posedge clk) disable iff (rst)
    (fifo_count == {CW{1'b0}}) |=> (fifo_count <= CW'(1))
  );

  a_no_w_in_resp: assert property (
    @(posedge clk) disable iff (rst)
    !((state == RESP) && wvalid && wready)
  );

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy. The head word is read
// straight from storage, so a push becomes visible one cycle later; there
// is no bypass. Pushes into a full FIFO and pops from an empty one are
// ignored.
module sync_fifo
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              full_s;
  logic              empty_s;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    full_s    = 1'b0;
    empty_s   = 1'b0;
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (count_r == FULL_CNT) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (count_r == {CW{1'b0}}) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    do_push_s = push && !full_s;
    do_pop_s  = pop && !empty_s;
  end

  // Storage write; contents need no reset because reads are masked when empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Empty FIFO presents zero so the read port never shows uninitialised data.
  always_comb begin
    pop_data = {DATA_W{1'b0}};
    if (empty_s) begin
      pop_data = {DATA_W{1'b0}};
    end else begin
      pop_data = mem_r[rd_ptr_r];
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/axi_w_sink.sv
// AXI write-data / write-response sink. Takes one single-beat W transfer
// at a time, answers it with a B response and buffers OKAY beats in a FIFO
// that local logic drains through a valid/ready read port.
module axi_w_sink
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic                   force_slverr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [15:0]            err_cnt
);

  sink_state_t             state_r;
  sink_state_t             state_nxt_s;
  resp_t                   bresp_r;
  logic                    wready_s;
  logic                    w_hs_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    empty_s;
  logic [DATA_W-1:0]       pop_data_s;
  logic [$clog2(DEPTH):0]  count_s;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic [15:0]             err_cnt_r;

  // Next state and handshake decode; wready comes only from registered state.
  always_comb begin
    state_nxt_s = state_r;
    wready_s    = 1'b0;
    w_hs_s      = 1'b0;
    case (state_r)
      ACCEPT: begin
        wready_s = !rst && !full_s;
        w_hs_s   = wvalid && wready_s;
        if (w_hs_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = ACCEPT;
        end
      end
      RESP: begin
        wready_s = 1'b0;
        w_hs_s   = 1'b0;
        if (bready) begin
          state_nxt_s = ACCEPT;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = ACCEPT;
      end
    endcase
  end

  // State register; reset abandons any outstanding response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCEPT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response code captured at the W handshake and held until the B handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      bresp_r <= OKAY;
    end else if (w_hs_s) begin
      if (force_slverr) begin
        bresp_r <= SLVERR;
      end else begin
        bresp_r <= OKAY;
      end
    end
  end

  // Beat counter wraps; error counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= 16'h0000;
    end else if (w_hs_s) begin
      if (force_slverr) begin
        err_cnt_r <= sat_inc16(err_cnt_r);
      end else begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
    end
  end

  assign push_s = w_hs_s && !force_slverr;
  assign pop_s  = !empty_s && rd_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (wdata),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  assign wready     = wready_s;
  assign bvalid     = (state_r == RESP);
  assign bresp      = bresp_r;
  assign rd_data    = pop_data_s;
  assign rd_valid   = !empty_s;
  assign fifo_count = count_s;
  assign beat_cnt   = beat_cnt_r;
  assign err_cnt    = err_cnt_r;

  axi_w_sink_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .state      (state_r),
    .wvalid     (wvalid),
    .wready     (wready_s),
    .bvalid     (bvalid),
    .bready     (bready),
    .bresp      (bresp),
    .fifo_count (count_s)
  );

endmodule

// File: doc/axi_w_sink.md
Name: axi_w_sink

Overview:
- AXI4 write-data/write-response slave that sits directly downstream of the team's W/B-only AXI write master.
- Accepts single-beat W transfers and buffers each accepted word in an internal FIFO.
- Returns one B response per beat.
- Exposes the buffered words to local logic through a valid/ready read port. It is the consumer endpoint for the master's data stream.

Parameters:
- DATA_W, 32, width of wdata and of each FIFO entry.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of the accepted-beat counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wdata  input  DATA_W  AXI write data.
- wvalid  input  1  AXI write data valid.
- wready  output  1  AXI write data ready.
- bresp  output  2  AXI write response.
- bvalid  output  1  AXI write response valid.
- bready  input  1  AXI write response ready.
- force_slverr  input  1  sampled on a W handshake: reject that beat with SLVERR.
- rd_data  output  DATA_W  head-of-FIFO word.
- rd_valid  output  1  FIFO not empty.
- rd_ready  input  1  consumer pops the head when high together with rd_valid.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- beat_cnt  output  CNT_W  number of beats accepted with OKAY.
- err_cnt  output  16  number of beats answered with SLVERR.

Behaviour:
- Reset (rst high at a clock edge):
  - state=ACCEPT; FIFO emptied; all counters 0.
  - bvalid=0, bresp=2'b00, wready=0 during reset, rd_valid=0, fifo_count=0.
  - Reset mid-transfer drops any pending response and all buffered data. No B is issued for a beat that was in flight.
- State machine, two states:
  - ACCEPT: wready = !full (combinational from registered state and count). A W handshake (wvalid&&wready) at edge N moves to RESP.
  - RESP: wready=0; bvalid=1 and bresp is registered and stable until the B handshake. bvalid&&bready at edge M returns to ACCEPT, so wready can be high from cycle M+1.
- One outstanding beat at a time. Best case is one beat per 2 cycles.
- Timing: W handshake at edge N gives bvalid high in cycle N+1. bvalid and bresp do not depend combinationally on bready.
- Response selection at the W handshake:
  - force_slverr=0: wdata is written to the FIFO, bresp=OKAY (2'b00), beat_cnt increments (wraps at 2^CNT_W).
  - force_slverr=1: data is discarded, nothing is written, bresp=SLVERR (2'b10), err_cnt increments and saturates at 16'hFFFF.
- FIFO:
  - Written data is visible on rd_data with rd_valid=1 in cycle N+1 (one-cycle latency, no combinational bypass).
  - Pop when rd_valid&&rd_ready.
  - Full: wready=0 even if a pop occurs in the same cycle (no write-through-when-full).
  - Empty: rd_valid=0; rd_data is don't-care but must not be X after reset; hold the last value or 0.
  - Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
  - Pointers wrap modulo DEPTH. fifo_count is the registered occupancy, 0..DEPTH.
- wvalid with wready low: nothing happens. The sink does not require wdata to be stable in that case.
- bready held high in ACCEPT: no effect.
- Assertions:
  - bresp stable while bvalid&&!bready.
  - fifo_count never exceeds DEPTH and never underflows.
  - No W handshake while state==RESP.

Decomposition:
- Package axi_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - sink_state_t enum: ACCEPT, RESP.
- Sub-module sync_fifo (parameters DATA_W, DEPTH):
  - ports push/push_data/pop/pop_data/full/empty/count, with the same clk/rst.
- The top level holds only the FSM, response register and counters.

Test Plan:
- Single beat: wdata=32'hDEADBEEF with wvalid and bready tied high → bvalid one cycle after the handshake, bresp=2'b00, rd_data=32'hDEADBEEF with rd_valid=1, beat_cnt=1, fifo_count=1.
- Backpressured B: bready low for 5 cycles after bvalid → bvalid and bresp held, wready=0 throughout; bready high → wready=1 the following cycle.
- Fill: 8 beats 32'h0..32'h7 with rd_ready=0 → fifo_count=8, wready=0 with wvalid pending; one pop → wready=1 next cycle, 9th beat 32'h8 accepted; read-out order 0..8.
- Error beat: force_slverr=1 with wdata=32'h12345678 → bresp=2'b10, err_cnt=1, fifo_count unchanged, beat_cnt unchanged.
- Simultaneous push/pop at count=3 → count stays 3; data order preserved across a pointer wrap (write 20 beats while draining).
- Reset mid-operation: rst asserted while in RESP with fifo_count=4 → next cycle bvalid=0, rd_valid=0, fifo_count=0, counters 0, wready=1 after rst drops.
